// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the EX-stage divide sequencer: ALU op codes that select a divide
// and a decode helper used by the sequencer.
package div_ctrl_pkg;

  localparam logic [4:0] DIV_CONTROL  = 5'b11010;
  localparam logic [4:0] DIVU_CONTROL = 5'b11011;

  function automatic logic is_div_op(input logic [4:0] op);
    return (op == DIV_CONTROL) || (op == DIVU_CONTROL);
  endfunction

endpackage

// File: rtl/div_ctrl.sv
// Sequencer between EX and the external multi-cycle divider: issues start/annul, stalls the
// pipeline while the divide is in flight and emits one HI/LO write per retired divide.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       alucontrol,
  input  logic [31:0]      srca,
  input  logic [31:0]      srcb,
  input  logic             flush_e,
  input  logic             stall_ext,
  input  logic             div_ready,
  input  logic [63:0]      div_result,
  output logic             div_start,
  output logic             div_signed,
  output logic             div_annul,
  output logic [31:0]      div_opa,
  output logic [31:0]      div_opb,
  output logic             div_stall,
  output logic             hilo_we,
  output logic [63:0]      hilo_wdata,
  output logic [CNT_W-1:0] div_cycles
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_cycles;
  logic [63:0]      r_result;

  logic w_is_div;
  logic w_zero_div;
  logic w_accept;

  assign w_is_div   = is_div_op(alucontrol);
  assign w_zero_div = (srcb == 32'd0);
  assign w_accept   = w_is_div && !flush_e;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = S_IDLE;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next_state = w_zero_div ? S_DONE : S_BUSY;
        else          w_next_state = S_IDLE;
      end
      S_BUSY: begin
        if (flush_e)        w_next_state = S_IDLE;
        else if (div_ready) w_next_state = S_DONE;
        else                w_next_state = S_BUSY;
      end
      S_DONE: begin
        if (!flush_e && stall_ext) w_next_state = S_DONE;
        else                       w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Outputs are forced low while rst is held so an EX-stage divide cannot leak a start
  // or stall through the asynchronously cleared state.
  always_comb begin
    div_start  = 1'b0;
    div_signed = 1'b0;
    div_annul  = 1'b0;
    div_opa    = 32'd0;
    div_opb    = 32'd0;
    div_stall  = 1'b0;
    hilo_we    = 1'b0;
    hilo_wdata = 64'd0;
    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            div_stall = 1'b1;
            if (!w_zero_div) begin
              div_start  = 1'b1;
              div_signed = (alucontrol == DIV_CONTROL);
              div_opa    = srca;
              div_opb    = srcb;
            end
          end
        end
        S_BUSY: begin
          div_stall = 1'b1;
          div_annul = flush_e;
        end
        S_DONE: begin
          hilo_wdata = r_result;
          hilo_we    = !flush_e && !stall_ext;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_cycles <= '0;
      r_result <= 64'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt <= '0;
            if (w_zero_div) r_result <= 64'd0;
          end
        end
        S_BUSY: begin
          if (!flush_e) begin
            if (div_ready) begin
              r_result <= div_result;
              r_cycles <= r_cnt;
            end else if (r_cnt != {CNT_W{1'b1}}) begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign div_cycles = r_cycles;

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: a behavioural divider answers start/annul after a
// programmable delay and every HI/LO write is matched against queued expectations.
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  localparam int CNT_W = 6;
  localparam logic [4:0] NOP_CONTROL = 5'd0;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       alucontrol;
  logic [31:0]      srca;
  logic [31:0]      srcb;
  logic             flush_e;
  logic             stall_ext;
  logic             div_ready;
  logic [63:0]      div_result;
  logic             div_start;
  logic             div_signed;
  logic             div_annul;
  logic [31:0]      div_opa;
  logic [31:0]      div_opb;
  logic             div_stall;
  logic             hilo_we;
  logic [63:0]      hilo_wdata;
  logic [CNT_W-1:0] div_cycles;

  div_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .alucontrol(alucontrol), .srca(srca), .srcb(srcb),
    .flush_e(flush_e), .stall_ext(stall_ext), .div_ready(div_ready), .div_result(div_result),
    .div_start(div_start), .div_signed(div_signed), .div_annul(div_annul),
    .div_opa(div_opa), .div_opb(div_opb), .div_stall(div_stall),
    .hilo_we(hilo_we), .hilo_wdata(hilo_wdata), .div_cycles(div_cycles)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] div_ref(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Behavioural divider: ready rises model_delay edges after the start edge.
  int          model_delay = 3;
  int          model_cnt;
  logic        model_busy;
  logic [63:0] model_res;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_busy <= 1'b0;
      model_cnt  <= 0;
      model_res  <= 64'd0;
      div_ready  <= 1'b0;
      div_result <= 64'd0;
    end else if (div_start) begin
      model_busy <= 1'b1;
      model_cnt  <= model_delay - 1;
      model_res  <= div_ref(div_signed, div_opa, div_opb);
      div_ready  <= 1'b0;
    end else if (div_annul) begin
      model_busy <= 1'b0;
      div_ready  <= 1'b0;
    end else if (model_busy) begin
      if (model_cnt == 0) begin
        div_ready  <= 1'b1;
        div_result <= model_res;
        model_busy <= 1'b0;
      end else begin
        model_cnt <= model_cnt - 1;
      end
    end
  end

  typedef struct {
    logic [63:0]      wdata;
    logic [CNT_W-1:0] cycles;
    bit               chk_cycles;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   we_count    = 0;
  int   start_count = 0;
  int   annul_count = 0;

  always @(negedge clk) begin
    if (div_start) start_count++;
    if (div_annul) annul_count++;
    if (hilo_we) begin
      we_count++;
      if (sb.size() == 0) begin
        check_val("unexpected_hilo_we", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check_val("hilo_wdata", hilo_wdata, mon_e.wdata);
        if (mon_e.chk_cycles) check_val("div_cycles", 64'(div_cycles), 64'(mon_e.cycles));
        $display("txn %0d hilo_wdata=%h div_cycles=%0d", we_count, hilo_wdata, div_cycles);
      end
    end
  end

  function automatic exp_t mk_exp(input logic [63:0] w, input int cyc, input bit chk);
    exp_t e;
    e.wdata      = w;
    e.cycles     = (cyc > 63) ? CNT_W'(63) : CNT_W'(cyc);
    e.chk_cycles = chk;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives a divide in the current IDLE cycle, checks the issue-cycle outputs, then retires it from EX.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int dly, input bit expect_start);
    alucontrol  = op;
    srca        = a;
    srcb        = b;
    model_delay = dly;
    @(negedge clk);
    check_val("issue_stall", 64'(div_stall), 64'd1);
    check_val("issue_start", 64'(div_start), 64'(expect_start));
    if (expect_start) begin
      check_val("issue_signed", 64'(div_signed), 64'(op == DIV_CONTROL));
      check_val("issue_opa", 64'(div_opa), 64'(a));
      check_val("issue_opb", 64'(div_opb), 64'(b));
    end
    @(posedge clk);
    #1;
    alucontrol = NOP_CONTROL;
    srca       = 32'd0;
    srcb       = 32'd0;
  endtask

  task automatic wait_we(input int budget);
    int base;
    int n;
    base = we_count;
    n    = 0;
    while (we_count == base && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_val("hilo_we_count", 64'(we_count - base), 64'd1);
  endtask

  task automatic flush_case(input int dly, input bit expect_ready);
    int a0;
    int w0;
    a0 = annul_count;
    w0 = we_count;
    issue(DIV_CONTROL, 32'd1000, 32'd10, dly, 1'b1);
    repeat (4) step();
    flush_e = 1'b1;
    @(negedge clk);
    check_val("flush_annul", 64'(div_annul), 64'd1);
    check_val("flush_stall", 64'(div_stall), 64'd1);
    if (expect_ready) check_val("flush_ready_coincident", 64'(div_ready), 64'd1);
    step();
    flush_e = 1'b0;
    @(negedge clk);
    check_val("post_flush_stall", 64'(div_stall), 64'd0);
    check_val("post_flush_annul", 64'(div_annul), 64'd0);
    repeat (30) @(negedge clk);
    #1;
    check_val("flush_no_we", 64'(we_count - w0), 64'd0);
    check_val("flush_annul_count", 64'(annul_count - a0), 64'd1);
  endtask

  initial begin
    int sc;
    int wc;
    int n;
    rst        = 1'b1;
    alucontrol = NOP_CONTROL;
    srca       = 32'd0;
    srcb       = 32'd0;
    flush_e    = 1'b0;
    stall_ext  = 1'b0;
    #12;
    check_val("rst_stall", 64'(div_stall), 64'd0);
    check_val("rst_start", 64'(div_start), 64'd0);
    check_val("rst_hilo_we", 64'(hilo_we), 64'd0);
    check_val("rst_wdata", hilo_wdata, 64'd0);
    check_val("rst_cycles", 64'(div_cycles), 64'd0);
    step();
    rst = 1'b0;
    step();

    // DIV 100/7
    sb.push_back(mk_exp({32'd2, 32'd14}, 5, 1'b1));
    issue(DIV_CONTROL, 32'd100, 32'd7, 5, 1'b1);
    wait_we(40);

    // DIVU 0xFFFFFFFF/16 with a 33-cycle divider
    step();
    sb.push_back(mk_exp({32'hF, 32'h0FFF_FFFF}, 33, 1'b1));
    issue(DIVU_CONTROL, 32'hFFFF_FFFF, 32'd16, 33, 1'b1);
    wait_we(60);

    // Busy counter saturates
    step();
    sb.push_back(mk_exp({32'd1, 32'd333}, 70, 1'b1));
    issue(DIVU_CONTROL, 32'd1000, 32'd3, 70, 1'b1);
    wait_we(100);

    // Divide by zero: no start, one stall cycle, zero result next cycle
    step();
    sc = start_count;
    sb.push_back(mk_exp(64'd0, 0, 1'b0));
    issue(DIV_CONTROL, 32'd55, 32'd0, 5, 1'b0);
    wait_we(1);
    check_val("zero_div_no_start", 64'(start_count - sc), 64'd0);

    // Flush in the 5th BUSY cycle, then flush coinciding with ready
    step();
    flush_case(20, 1'b0);
    step();
    flush_case(4, 1'b1);

    // External stall holds DONE for 3 cycles
    step();
    sb.push_back(mk_exp(div_ref(1'b1, -32'sd50, 32'd7), 3, 1'b1));
    sc = start_count;
    issue(DIV_CONTROL, -32'sd50, 32'd7, 3, 1'b1);
    stall_ext = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (div_stall && n < 20);
    check_val("done_reached", 64'(div_stall), 64'd0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      check_val("stall_hold_we", 64'(hilo_we), 64'd0);
      check_val("stall_hold_start", 64'(div_start), 64'd0);
      @(posedge clk);
      #1;
      alucontrol = DIV_CONTROL;
      srca       = -32'sd50;
      srcb       = 32'd7;
    end
    stall_ext  = 1'b0;
    alucontrol = NOP_CONTROL;
    srca       = 32'd0;
    srcb       = 32'd0;
    wc = we_count;
    @(negedge clk);
    #1;
    check_val("stall_release_we", 64'(we_count - wc), 64'd1);
    @(negedge clk);
    #1;
    check_val("stall_single_we", 64'(we_count - wc), 64'd1);
    check_val("stall_no_reissue", 64'(start_count - sc), 64'd1);

    // Back-to-back divides
    step();
    sc = start_count;
    wc = we_count;
    sb.push_back(mk_exp(div_ref(1'b1, 32'd81, 32'd9), 2, 1'b1));
    issue(DIV_CONTROL, 32'd81, 32'd9, 2, 1'b1);
    wait_we(20);
    step();
    sb.push_back(mk_exp(div_ref(1'b0, 32'd77, 32'd5), 2, 1'b1));
    issue(DIVU_CONTROL, 32'd77, 32'd5, 2, 1'b1);
    wait_we(20);
    check_val("b2b_starts", 64'(start_count - sc), 64'd2);
    check_val("b2b_writes", 64'(we_count - wc), 64'd2);

    // Reset in the middle of BUSY
    step();
    wc = we_count;
    sc = annul_count;
    issue(DIV_CONTROL, 32'd500, 32'd3, 20, 1'b1);
    repeat (3) step();
    alucontrol = DIV_CONTROL;
    srca       = 32'd9;
    srcb       = 32'd2;
    rst        = 1'b1;
    #2;
    check_val("mid_rst_stall", 64'(div_stall), 64'd0);
    check_val("mid_rst_start", 64'(div_start), 64'd0);
    check_val("mid_rst_annul", 64'(div_annul), 64'd0);
    check_val("mid_rst_hilo_we", 64'(hilo_we), 64'd0);
    check_val("mid_rst_wdata", hilo_wdata, 64'd0);
    check_val("mid_rst_cycles", 64'(div_cycles), 64'd0);
    step();
    alucontrol = NOP_CONTROL;
    srca       = 32'd0;
    srcb       = 32'd0;
    rst        = 1'b0;
    @(negedge clk);
    check_val("post_rst_stall", 64'(div_stall), 64'd0);
    repeat (30) @(negedge clk);
    #1;
    check_val("post_rst_no_we", 64'(we_count - wc), 64'd0);
    check_val("post_rst_no_annul", 64'(annul_count - sc), 64'd0);

    check_val("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
